// File: rtl/unet_pkg.sv
// Shared definitions for the UNET host controller: status codes, FSM states
// and the default transfer sizes.
package unet_pkg;

  localparam int N_WEIGHTS_DEF = 939;
  localparam int N_DATA_DEF    = 98369;
  localparam int N_OUT_DEF     = 65536;

  typedef enum logic [2:0] {
    CTRL_CALCULATING  = 3'd0,
    CTRL_SEND_WEIGHTS = 3'd1,
    CTRL_SEND_DATA    = 3'd2,
    CTRL_DATA_READY   = 3'd3,
    CTRL_SENDING      = 3'd4,
    CTRL_IDLE         = 3'd5
  } ctrl_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WLOAD    = 3'd1,
    S_DLOAD    = 3'd2,
    S_CALC     = 3'd3,
    S_READY    = 3'd4,
    S_PREFETCH = 3'd5,
    S_SEND     = 3'd6
  } state_t;

endpackage

// File: rtl/unet_xfer_counter.sv
// Word counter for load and readout phases: counts 0..terminal and returns to
// zero after the terminal word, so it never wraps through its full range.
module unet_xfer_counter #(
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] terminal,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == terminal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/unet_host_ctrl.sv
// Host-side sequencer for the UNET core: streams weights and input data into
// the core RAMs, starts the computation and streams the result back out.
module unet_host_ctrl
  import unet_pkg::*;
#(
  parameter int N_WEIGHTS = N_WEIGHTS_DEF,
  parameter int N_DATA    = N_DATA_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int AW        = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          unet_enpulse,
  input  logic [31:0]   data_in,
  output logic [2:0]    ctrl,
  output logic          busy,
  output logic [31:0]   data_out,
  output logic          wt_we,
  output logic [AW-1:0] wt_addr,
  output logic [31:0]   wt_wdata,
  output logic          in_we,
  output logic [AW-1:0] in_addr,
  output logic [31:0]   in_wdata,
  output logic          core_start,
  input  logic          core_done,
  output logic [AW-1:0] out_raddr,
  input  logic [31:0]   out_rdata
);

  localparam int N_MAX = (N_WEIGHTS > N_DATA) ?
                         ((N_WEIGHTS > N_OUT) ? N_WEIGHTS : N_OUT) :
                         ((N_DATA > N_OUT) ? N_DATA : N_OUT);
  localparam int CW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam logic [AW-1:0] RADDR_LAST = AW'(N_OUT - 1);

  state_t        state;
  logic          armed;
  logic          weights_loaded;
  logic          req;
  logic          cnt_en;
  logic [CW-1:0] terminal;
  logic [CW-1:0] count;
  logic          last;
  logic [AW-1:0] raddr_next;

  // Host handshake: unet_enpulse is a level; a request is one clk edge with
  // unet_enpulse=1 while armed. Arming needs unet_enpulse seen low while not
  // busy, so a held level gives exactly one request and busy-time pulses vanish.
  assign req = unet_enpulse && armed;

  assign cnt_en = (state == S_WLOAD) || (state == S_DLOAD) || (state == S_SEND);

  always_comb begin
    terminal = '0;
    case (state)
      S_WLOAD: terminal = CW'(N_WEIGHTS - 1);
      S_DLOAD: terminal = CW'(N_DATA - 1);
      S_SEND:  terminal = CW'(N_OUT - 1);
      default: terminal = '0;
    endcase
  end

  unet_xfer_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (!cnt_en),
    .enable   (cnt_en),
    .terminal (terminal),
    .count    (count),
    .last     (last)
  );

  // Writes are decoded from the state flop so a reset kills them at once.
  assign wt_we    = (state == S_WLOAD);
  assign wt_addr  = wt_we ? AW'(count) : '0;
  assign wt_wdata = wt_we ? data_in : '0;
  assign in_we    = (state == S_DLOAD);
  assign in_addr  = in_we ? AW'(count) : '0;
  assign in_wdata = in_we ? data_in : '0;

  // Read address runs one word ahead of data_out to hide the RAM latency.
  assign raddr_next = (out_raddr == RADDR_LAST) ? out_raddr : out_raddr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ctrl           <= CTRL_IDLE;
      busy           <= 1'b0;
      core_start     <= 1'b0;
      data_out       <= '0;
      out_raddr      <= '0;
      weights_loaded <= 1'b0;
      armed          <= 1'b0;
    end else begin
      core_start <= 1'b0;
      data_out   <= '0;
      case (state)
        S_IDLE: begin
          if (req) begin
            armed <= 1'b0;
            busy  <= 1'b1;
            if (weights_loaded) begin
              state <= S_DLOAD;
              ctrl  <= CTRL_SEND_DATA;
            end else begin
              state <= S_WLOAD;
              ctrl  <= CTRL_SEND_WEIGHTS;
            end
          end else if (!unet_enpulse) begin
            armed <= 1'b1;
          end
        end
        S_WLOAD: begin
          if (last) begin
            state          <= S_IDLE;
            ctrl           <= CTRL_IDLE;
            busy           <= 1'b0;
            weights_loaded <= 1'b1;
          end
        end
        S_DLOAD: begin
          if (last) begin
            state      <= S_CALC;
            ctrl       <= CTRL_CALCULATING;
            core_start <= 1'b1;
          end
        end
        S_CALC: begin
          if (core_done) begin
            state <= S_READY;
            ctrl  <= CTRL_DATA_READY;
            busy  <= 1'b0;
          end
        end
        S_READY: begin
          if (req) begin
            armed     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_PREFETCH;
            out_raddr <= raddr_next;
          end else if (!unet_enpulse) begin
            armed <= 1'b1;
          end
        end
        S_PREFETCH: begin
          state     <= S_SEND;
          ctrl      <= CTRL_SENDING;
          data_out  <= out_rdata;
          out_raddr <= raddr_next;
        end
        S_SEND: begin
          if (last) begin
            state     <= S_IDLE;
            ctrl      <= CTRL_IDLE;
            busy      <= 1'b0;
            out_raddr <= '0;
          end else begin
            data_out  <= out_rdata;
            out_raddr <= raddr_next;
          end
        end
        default: begin
          state <= S_IDLE;
          ctrl  <= CTRL_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
